pwm_duty_ramp: RTL and testbench

Soft-start / slew-limited duty-cycle sequencer that sits directly upstream of the team's 8-bit PWM generator and drives its duty-cycle input. It accepts a target duty over a valid/ready handshake and ramps the output duty toward that target by a programmable step once per PWM period. Updates occur only at period boundaries, so the PWM never sees a mid-period duty change. An internal period counter mirrors the generator's free-running period.

---
 rtl/pwm_duty_ramp.sv | 136 +++++++++++++
 tb/tb_pwm_duty_ramp.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_duty_ramp.sv
// Slew-limited duty sequencer feeding the PWM generator.
// Duty moves toward the accepted target by one step per PWM period.
module pwm_duty_ramp #(
    parameter int WIDTH    = 8,
    parameter int STEP_W   = 8,
    parameter int PERIOD_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [WIDTH-1:0]  target,
    input  logic [STEP_W-1:0] step,
    input  logic              target_valid,
    output logic              target_ready,
    output logic [WIDTH-1:0]  duty,
    output logic              period_start,
    output logic              busy,
    output logic              done
);

    localparam int CW = ((WIDTH > STEP_W) ? WIDTH : STEP_W) + 1;

    typedef enum logic [1:0] {
        IDLE,
        UP,
        DOWN
    } state_t;

    state_t              state_q, state_d;
    logic [PERIOD_W-1:0] pcnt_q, pcnt_d;
    logic                ps_q, ps_d;
    logic                done_q, done_d;
    logic [WIDTH-1:0]    duty_q, duty_d;
    logic [WIDTH-1:0]    tgt_q, tgt_d;
    logic [STEP_W-1:0]   step_q, step_d;

    logic                tick;
    logic                accept;
    logic [CW-1:0]       gap;
    logic [CW-1:0]       step_x;

    assign tick   = &pcnt_q;
    assign accept = target_valid && (state_q == IDLE);
    assign step_x = CW'(step_q);

    // Distance left to travel, widened so a large step compares cleanly.
    always_comb begin
        gap = '0;
        if (state_q == UP) begin
            gap = CW'(tgt_q) - CW'(duty_q);
        end else begin
            gap = CW'(duty_q) - CW'(tgt_q);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            pcnt_q  <= '0;
            ps_q    <= 1'b0;
            done_q  <= 1'b0;
            duty_q  <= '0;
            tgt_q   <= '0;
            step_q  <= '0;
        end else begin
            state_q <= state_d;
            pcnt_q  <= pcnt_d;
            ps_q    <= ps_d;
            done_q  <= done_d;
            duty_q  <= duty_d;
            tgt_q   <= tgt_d;
            step_q  <= step_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pcnt_d  = pcnt_q + PERIOD_W'(1);
        ps_d    = tick;
        done_d  = 1'b0;
        duty_d  = duty_q;
        tgt_d   = tgt_q;
        step_d  = step_q;

        if (accept) begin
            tgt_d  = target;
            step_d = (step == '0) ? STEP_W'(1) : step;
        end

        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    if (target > duty_q) begin
                        state_d = UP;
                    end else if (target < duty_q) begin
                        state_d = DOWN;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            UP: begin
                if (tick && en) begin
                    if (gap <= step_x) begin
                        duty_d  = tgt_q;
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end else begin
                        duty_d = duty_q + WIDTH'(step_q);
                    end
                end
            end
            DOWN: begin
                if (tick && en) begin
                    if (gap <= step_x) begin
                        duty_d  = tgt_q;
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end else begin
                        duty_d = duty_q - WIDTH'(step_q);
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign target_ready = (state_q == IDLE);
    assign busy         = (state_q != IDLE);
    assign duty         = duty_q;
    assign period_start = ps_q;
    assign done         = done_q;

endmodule

// File: tb/tb_pwm_duty_ramp.sv
// Directed bench for pwm_duty_ramp with a per-tick duty scoreboard.
// Uses a 16-clock period and a 9-bit step to reach the step>=256 case.
module tb_pwm_duty_ramp;

    localparam int WIDTH    = 8;
    localparam int STEP_W   = 9;
    localparam int PERIOD_W = 4;
    localparam int PER      = 16;

    typedef struct {
        int d;
        bit fin;
    } exp_t;

    logic              clk;
    logic              rst;
    logic              en;
    logic [WIDTH-1:0]  target;
    logic [STEP_W-1:0] step;
    logic              target_valid;
    logic              target_ready;
    logic [WIDTH-1:0]  duty;
    logic              period_start;
    logic              busy;
    logic              done;

    int   total;
    int   bad;
    int   ncyc;
    int   m_duty;
    bit   m_busy;
    exp_t exp_q[$];

    pwm_duty_ramp #(
        .WIDTH(WIDTH),
        .STEP_W(STEP_W),
        .PERIOD_W(PERIOD_W)
    ) dut (
        .clk(clk),
        .rst(rst),
        .en(en),
        .target(target),
        .step(step),
        .target_valid(target_valid),
        .target_ready(target_ready),
        .duty(duty),
        .period_start(period_start),
        .busy(busy),
        .done(done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk or posedge rst) begin
        if (rst) ncyc <= 0;
        else     ncyc <= ncyc + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    // Expected duty sequence for one ramp, one entry per enabled tick.
    task automatic plan(input int tgt, input int stp);
        int d;
        int s;
        exp_t e;
        d = m_duty;
        s = (stp == 0) ? 1 : stp;
        while (d != tgt) begin
            if (tgt > d) d = (tgt - d <= s) ? tgt : d + s;
            else         d = (d - tgt <= s) ? tgt : d - s;
            e.d   = d;
            e.fin = (d == tgt);
            exp_q.push_back(e);
        end
    endtask

    task automatic offer(input int tgt, input int stp);
        target       = tgt[WIDTH-1:0];
        step         = stp[STEP_W-1:0];
        target_valid = 1'b1;
        @(negedge clk);
        target_valid = 1'b0;
        chk("acc_busy", {31'd0, busy}, {31'd0, tgt != m_duty});
        chk("acc_done", {31'd0, done}, {31'd0, tgt == m_duty});
        chk("acc_duty", {24'd0, duty}, m_duty);
        plan(tgt, stp);
        m_busy = (tgt != m_duty);
    endtask

    task automatic wait_ps();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 2 * PER; i++) begin
            @(negedge clk);
            if (period_start === 1'b1) begin
                ok = 1'b1;
                break;
            end
            chk("hold_duty", {24'd0, duty}, m_duty);
            chk("no_done", {31'd0, done}, 0);
            chk("ready", {31'd0, target_ready}, {31'd0, !m_busy});
        end
        if (!ok) chk("ps_timeout", 0, 1);
    endtask

    task automatic tick_check();
        exp_t e;
        wait_ps();
        if (exp_q.size() == 0) begin
            chk("sb_empty", 0, 1);
            return;
        end
        e = exp_q.pop_front();
        chk("tick_duty", {24'd0, duty}, e.d);
        chk("tick_done", {31'd0, done}, {31'd0, e.fin});
        chk("tick_busy", {31'd0, busy}, {31'd0, !e.fin});
        m_duty = e.d;
        m_busy = !e.fin;
    endtask

    task automatic frozen_tick();
        wait_ps();
        chk("frz_duty", {24'd0, duty}, m_duty);
        chk("frz_done", {31'd0, done}, 0);
        chk("frz_busy", {31'd0, busy}, 1);
        chk("frz_ready", {31'd0, target_ready}, 0);
    endtask

    initial begin
        total        = 0;
        bad          = 0;
        m_duty       = 0;
        m_busy       = 1'b0;
        rst          = 1'b1;
        en           = 1'b1;
        target       = '0;
        step         = '0;
        target_valid = 1'b0;

        repeat (3) @(negedge clk);
        chk("rst_duty", {24'd0, duty}, 0);
        chk("rst_busy", {31'd0, busy}, 0);
        chk("rst_ready", {31'd0, target_ready}, 1);
        chk("rst_done", {31'd0, done}, 0);
        chk("rst_ps", {31'd0, period_start}, 0);
        rst = 1'b0;

        // Free-running period pulses with no stimulus.
        for (int i = 0; i < 3 * PER; i++) begin
            @(negedge clk);
            chk("ps_timing", {31'd0, period_start},
                {31'd0, (ncyc % PER) == 0});
            chk("idle_duty", {24'd0, duty}, 0);
        end

        offer(40, 16);
        repeat (3) tick_check();
        @(negedge clk);
        chk("done_1cyc", {31'd0, done}, 0);

        offer(5, 20);
        repeat (2) tick_check();

        // Step wider than the duty range lands on target in one tick.
        offer(253, 256);
        tick_check();

        offer(255, 0);
        repeat (2) tick_check();
        wait_ps();
        chk("sat_duty", {24'd0, duty}, 255);
        chk("sat_done", {31'd0, done}, 0);

        offer(55, 50);
        tick_check();
        en           = 1'b0;
        target       = 8'd55;
        step         = 9'd1;
        target_valid = 1'b1;
        repeat (3) frozen_tick();
        en = 1'b1;
        repeat (3) tick_check();
        @(negedge clk);
        target_valid = 1'b0;
        chk("late_acc_done", {31'd0, done}, 1);
        chk("late_acc_busy", {31'd0, busy}, 0);
        chk("late_acc_duty", {24'd0, duty}, 55);
        @(negedge clk);
        chk("late_done_off", {31'd0, done}, 0);

        offer(0, 55);
        tick_check();
        offer(64, 32);
        tick_check();
        chk("pre_rst_duty", {24'd0, duty}, 32);

        // Asynchronous reset in the middle of a ramp.
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("arst_duty", {24'd0, duty}, 0);
        chk("arst_busy", {31'd0, busy}, 0);
        chk("arst_done", {31'd0, done}, 0);
        chk("arst_ready", {31'd0, target_ready}, 1);
        exp_q.delete();
        m_duty = 0;
        m_busy = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        wait_ps();
        chk("rst_pcnt", ncyc, PER);

        offer(0, 5);
        @(negedge clk);
        chk("eq_done_off", {31'd0, done}, 0);
        wait_ps();
        chk("eq_duty", {24'd0, duty}, 0);
        chk("sb_left", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
